// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through and runs a request/response FSM for loads
// and stores. Loads are lane-shifted and extended, stores get lane-shifted data and strobes.
module mem_lsu #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_hold_i,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_rd_data,
   input  logic [4:0]      ex_rd_addr,
   input  logic            ex_rd_ena,
   input  logic [3:0]      ex_mem_op,
   input  logic [XLEN-1:0] ex_mem_addr,
   input  logic [XLEN-1:0] ex_mem_wdata,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic            dmem_req_wen,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [7:0]      dmem_req_wstrb,
   input  logic            dmem_resp_valid,
   input  logic [XLEN-1:0] dmem_resp_rdata,
   output logic [XLEN-1:0] mem_rd_data,
   output logic [4:0]      mem_rd_addr,
   output logic            mem_rd_ena,
   output logic [XLEN-1:0] mem_pc_o,
   output logic            mem_stall_req,
   output logic            mem_misalign
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e          state_q;
   logic [3:0]      op_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rd_data_q;
   logic [XLEN-1:0] pc_q;
   logic [4:0]      rd_addr_q;
   logic            rd_ena_q;

   logic ex_mem;
   logic ex_misal;
   logic accept;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd7);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op >= 4'd8) && (op <= 4'd11);
   endfunction

   // log2 of the access size in bytes
   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         4'd1, 4'd5, 4'd8:  return 2'd0;
         4'd2, 4'd6, 4'd9:  return 2'd1;
         4'd3, 4'd7, 4'd10: return 2'd2;
         default:           return 2'd3;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [3:0] op, input logic [2:0] off);
      case (op_size(op))
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [3:0] op, input logic [2:0] off,
                                                input logic [XLEN-1:0] rdata);
      logic [XLEN-1:0] sh;
      logic            sgn;
      sh  = rdata >> {off, 3'b000};
      sgn = (op <= 4'd4);
      case (op_size(op))
         2'd0:    return {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
         2'd1:    return {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
         2'd2:    return {{(XLEN-32){sgn & sh[31]}}, sh[31:0]};
         default: return sh;
      endcase
   endfunction

   function automatic logic [7:0] strb_base(input logic [3:0] op);
      case (op_size(op))
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   always_comb begin
      ex_mem   = ex_valid_i & (op_is_load(ex_mem_op) | op_is_store(ex_mem_op));
      ex_misal = ex_mem & is_misaligned(ex_mem_op, ex_mem_addr[2:0]);
      accept   = (state_q == StIdle) & ex_mem & ~ex_misal;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         pc_q      <= '0;
         rd_addr_q <= '0;
         rd_ena_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q      <= ex_mem_op;
                  addr_q    <= ex_mem_addr;
                  wdata_q   <= ex_mem_wdata;
                  rd_data_q <= '0;
                  pc_q      <= ex_pc_i;
                  rd_addr_q <= ex_rd_addr;
                  rd_ena_q  <= ex_rd_ena;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               if (dmem_req_ready) state_q <= op_is_store(op_q) ? StDone : StWait;
            end
            StWait: begin
               if (dmem_resp_valid) begin
                  rd_data_q <= load_ext(op_q, addr_q[2:0], dmem_resp_rdata);
                  state_q   <= StDone;
               end
            end
            default: begin
               if (!mem_hold_i) state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      dmem_req_valid = 1'b0;
      dmem_req_addr  = '0;
      dmem_req_wen   = 1'b0;
      dmem_req_wdata = '0;
      dmem_req_wstrb = '0;
      mem_rd_data    = '0;
      mem_rd_addr    = '0;
      mem_rd_ena     = 1'b0;
      mem_pc_o       = '0;
      mem_stall_req  = 1'b0;
      mem_misalign   = 1'b0;
      if (rst) begin
         dmem_req_addr = {addr_q[XLEN-1:3], 3'b000};
         if (op_is_store(op_q)) begin
            dmem_req_wen   = 1'b1;
            dmem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
            dmem_req_wstrb = strb_base(op_q) << addr_q[2:0];
         end
         case (state_q)
            StIdle: begin
               mem_rd_data   = ex_rd_data;
               mem_rd_addr   = ex_rd_addr;
               mem_rd_ena    = ex_valid_i & ex_rd_ena & ~ex_mem;
               mem_pc_o      = ex_pc_i;
               mem_stall_req = accept;
               mem_misalign  = ex_misal;
            end
            StReq: begin
               dmem_req_valid = 1'b1;
               mem_stall_req  = 1'b1;
               mem_rd_addr    = rd_addr_q;
               mem_pc_o       = pc_q;
            end
            StWait: begin
               mem_stall_req = 1'b1;
               mem_rd_addr   = rd_addr_q;
               mem_pc_o      = pc_q;
            end
            default: begin
               mem_rd_data = rd_data_q;
               mem_rd_addr = rd_addr_q;
               mem_rd_ena  = rd_ena_q & op_is_load(op_q);
               mem_pc_o    = pc_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised self-checking bench for mem_lsu against a byte-level behavioural model.
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        mem_hold_i;
   logic        ex_valid_i;
   logic [63:0] ex_pc_i;
   logic [63:0] ex_rd_data;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_ena;
   logic [3:0]  ex_mem_op;
   logic [63:0] ex_mem_addr;
   logic [63:0] ex_mem_wdata;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_req_addr;
   logic        dmem_req_wen;
   logic [63:0] dmem_req_wdata;
   logic [7:0]  dmem_req_wstrb;
   logic        dmem_resp_valid;
   logic [63:0] dmem_resp_rdata;
   logic [63:0] mem_rd_data;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_ena;
   logic [63:0] mem_pc_o;
   logic        mem_stall_req;
   logic        mem_misalign;

   int n_err = 0;
   int n_chk = 0;

   // observations collected by do_mem
   logic [63:0] o_req_addr, o_req_wdata, o_res_data, o_res_pc, g_pc;
   logic [7:0]  o_req_wstrb;
   logic [4:0]  o_res_addr;
   logic        o_req_wen, o_unstable, o_held_bad, o_timeout, o_res_ena;
   int          o_stalls, o_done_n, o_req_n;

   mem_lsu #(.XLEN(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_hold_i     (mem_hold_i),
      .ex_valid_i     (ex_valid_i),
      .ex_pc_i        (ex_pc_i),
      .ex_rd_data     (ex_rd_data),
      .ex_rd_addr     (ex_rd_addr),
      .ex_rd_ena      (ex_rd_ena),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_addr    (ex_mem_addr),
      .ex_mem_wdata   (ex_mem_wdata),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_req_addr  (dmem_req_addr),
      .dmem_req_wen   (dmem_req_wen),
      .dmem_req_wdata (dmem_req_wdata),
      .dmem_req_wstrb (dmem_req_wstrb),
      .dmem_resp_valid(dmem_resp_valid),
      .dmem_resp_rdata(dmem_resp_rdata),
      .mem_rd_data    (mem_rd_data),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_ena     (mem_rd_ena),
      .mem_pc_o       (mem_pc_o),
      .mem_stall_req  (mem_stall_req),
      .mem_misalign   (mem_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model: access size and signedness straight from the opcode table.
   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd5, 4'd8:  return 1;
         4'd2, 4'd6, 4'd9:  return 2;
         4'd3, 4'd7, 4'd10: return 4;
         default:           return 8;
      endcase
   endfunction

   function automatic logic [63:0] model_load(input logic [3:0] op, input logic [63:0] addr,
                                              input logic [63:0] rdata);
      int          n;
      logic [63:0] v, mask;
      n = nbytes(op);
      v = rdata >> (8 * int'(addr[2:0]));
      if (n == 8) return v;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = v & mask;
      if (op <= 4'd4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] model_strb(input logic [3:0] op, input logic [63:0] addr);
      logic [7:0] s;
      int         off;
      s   = '0;
      off = int'(addr[2:0]);
      for (int k = 0; k < 8; k++) if (k >= off && k < off + nbytes(op)) s[k] = 1'b1;
      return s;
   endfunction

   task automatic clear_inputs();
      mem_hold_i = 0; ex_valid_i = 0; ex_pc_i = '0; ex_rd_data = '0; ex_rd_addr = '0;
      ex_rd_ena = 0; ex_mem_op = '0; ex_mem_addr = '0; ex_mem_wdata = '0;
      dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = '0;
   endtask

   // Drives one memory op through a behavioural bus and records what the DUT showed.
   // Called at posedge+1, returns at posedge+1 with the stage idle-presented.
   task automatic do_mem(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic [4:0] rd, input int rdy_d,
                         input int resp_d, input int hold_n);
      logic in_wait, fin;
      int   wait_n;
      in_wait = 0; fin = 0; wait_n = 0;
      o_stalls = 0; o_done_n = 0; o_req_n = 0;
      o_unstable = 0; o_held_bad = 0; o_timeout = 0;
      o_req_addr = '0; o_req_wdata = '0; o_req_wstrb = '0; o_req_wen = 0;
      o_res_data = '0; o_res_pc = '0; o_res_addr = '0; o_res_ena = 0;
      ex_valid_i = 1; ex_mem_op = op; ex_mem_addr = addr; ex_mem_wdata = wdata;
      ex_rd_addr = rd; ex_rd_ena = 1; ex_rd_data = {$urandom, $urandom};
      ex_pc_i = {$urandom, $urandom}; g_pc = ex_pc_i;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         dmem_req_ready = 0; dmem_resp_valid = 0; mem_hold_i = 0;
         dmem_resp_rdata = {$urandom, $urandom};
         #1;
         if (mem_stall_req) o_stalls++;
         if (dmem_req_valid) begin
            if (o_req_n == 0) begin
               o_req_addr = dmem_req_addr; o_req_wdata = dmem_req_wdata;
               o_req_wstrb = dmem_req_wstrb; o_req_wen = dmem_req_wen;
            end else if (dmem_req_addr !== o_req_addr || dmem_req_wdata !== o_req_wdata ||
                         dmem_req_wstrb !== o_req_wstrb || dmem_req_wen !== o_req_wen) begin
               o_unstable = 1;
            end
            dmem_req_ready = (o_req_n == rdy_d);
            o_req_n++;
         end
         if (in_wait) begin
            if (wait_n == resp_d) begin
               dmem_resp_valid = 1; dmem_resp_rdata = rdata;
            end
            wait_n++;
         end
         if (cyc > 0 && !mem_stall_req) begin
            if (o_done_n == 0) begin
               o_res_data = mem_rd_data; o_res_addr = mem_rd_addr;
               o_res_ena = mem_rd_ena; o_res_pc = mem_pc_o;
            end else if (mem_rd_data !== o_res_data || mem_rd_addr !== o_res_addr ||
                         mem_rd_ena !== o_res_ena || mem_pc_o !== o_res_pc) begin
               o_held_bad = 1;
            end
            mem_hold_i = (o_done_n < hold_n);
            o_done_n++;
         end
         @(posedge clk);
         if (dmem_req_ready) in_wait = (op < 4'd8);
         if (dmem_resp_valid) in_wait = 0;
         if (o_done_n > 0 && !mem_hold_i) fin = 1;
         #1;
      end
      if (!fin) o_timeout = 1;
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      ex_valid_i = 1; ex_rd_data = 64'hDEAD; ex_rd_addr = 3; ex_rd_ena = 1; ex_pc_i = 64'h100;
      @(posedge clk); #1; @(posedge clk); #1;
      n_chk++; if (mem_rd_data !== 64'h0) begin n_err++;
         $display("FAIL rst_rd_data: got %h want 0", mem_rd_data); end
      n_chk++; if (mem_rd_ena !== 1'b0 || mem_rd_addr !== 5'd0) begin n_err++;
         $display("FAIL rst_rd_ena_addr: got %b/%0d want 0/0", mem_rd_ena, mem_rd_addr); end
      n_chk++; if (mem_pc_o !== 64'h0) begin n_err++;
         $display("FAIL rst_pc: got %h want 0", mem_pc_o); end
      ex_mem_op = 4'd3; ex_mem_addr = 64'h2;
      #1;
      n_chk++; if (mem_misalign !== 1'b0 || mem_stall_req !== 1'b0) begin n_err++;
         $display("FAIL rst_misalign_stall: got %b/%b want 0/0", mem_misalign, mem_stall_req); end
      ex_mem_op = 4'd4; ex_mem_addr = 64'h0;
      @(posedge clk); #1;
      n_chk++; if (dmem_req_valid !== 1'b0 || mem_stall_req !== 1'b0) begin n_err++;
         $display("FAIL rst_req: got %b/%b want 0/0", dmem_req_valid, mem_stall_req); end
      rst = 1;
      clear_inputs();
      @(posedge clk); #1;
      n_chk++; if (dmem_req_valid !== 1'b0 || mem_stall_req !== 1'b0) begin n_err++;
         $display("FAIL rst_release_idle: got %b/%b want 0/0", dmem_req_valid, mem_stall_req); end
   endtask

   task automatic test_alu();
      ex_valid_i = 1; ex_rd_data = 64'h1234; ex_rd_addr = 5; ex_rd_ena = 1; ex_mem_op = 0;
      ex_pc_i = 64'h80;
      #1;
      n_chk++; if (mem_rd_data !== 64'h1234 || mem_rd_addr !== 5'd5 || mem_rd_ena !== 1'b1)
         begin n_err++; $display("FAIL alu_pass: got %h/%0d/%b want 1234/5/1",
         mem_rd_data, mem_rd_addr, mem_rd_ena); end
      n_chk++; if (mem_stall_req !== 1'b0 || mem_pc_o !== 64'h80) begin n_err++;
         $display("FAIL alu_stall_pc: got %b/%h want 0/80", mem_stall_req, mem_pc_o); end
      ex_valid_i = 0;
      #1;
      n_chk++; if (mem_rd_ena !== 1'b0) begin n_err++;
         $display("FAIL alu_invalid_ena: got %b want 0", mem_rd_ena); end
      clear_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_lb();
      do_mem(4'd1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 0, 0, 0);
      n_chk++; if (o_timeout || o_req_addr !== 64'h1000 || o_req_wen !== 1'b0) begin n_err++;
         $display("FAIL lb_req: got to=%b addr=%h wen=%b want 0/1000/0",
         o_timeout, o_req_addr, o_req_wen); end
      n_chk++; if (o_res_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++;
         $display("FAIL lb_data: got %h want ffffffffffffff80", o_res_data); end
      n_chk++; if (o_res_ena !== 1'b1 || o_res_addr !== 5'd7 || o_res_pc !== g_pc) begin
         n_err++; $display("FAIL lb_wb: got %b/%0d/%h want 1/7/%h",
         o_res_ena, o_res_addr, o_res_pc, g_pc); end
      n_chk++; if (o_stalls != 3) begin n_err++;
         $display("FAIL lb_stall: got %0d want 3", o_stalls); end
   endtask

   task automatic test_sh();
      do_mem(4'd9, 64'h1006, 64'hABCD, 64'h0, 5'd4, 0, 0, 0);
      n_chk++; if (o_req_wstrb !== 8'hC0 || o_req_wen !== 1'b1) begin n_err++;
         $display("FAIL sh_strb: got %h/%b want c0/1", o_req_wstrb, o_req_wen); end
      n_chk++; if (o_req_wdata !== 64'hABCD_0000_0000_0000) begin n_err++;
         $display("FAIL sh_wdata: got %h want abcd000000000000", o_req_wdata); end
      n_chk++; if (o_timeout || o_res_ena !== 1'b0 || o_stalls != 2) begin n_err++;
         $display("FAIL sh_done: got to=%b ena=%b stall=%0d want 0/0/2",
         o_timeout, o_res_ena, o_stalls); end
   endtask

   task automatic test_misalign();
      ex_valid_i = 1; ex_mem_op = 4'd3; ex_mem_addr = 64'h1002; ex_rd_addr = 2; ex_rd_ena = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (mem_misalign !== 1'b1 || mem_rd_ena !== 1'b0) begin n_err++;
            $display("FAIL misalign_flag: got %b/%b want 1/0", mem_misalign, mem_rd_ena); end
         n_chk++; if (dmem_req_valid !== 1'b0 || mem_stall_req !== 1'b0) begin n_err++;
            $display("FAIL misalign_noreq: got %b/%b want 0/0", dmem_req_valid, mem_stall_req);
         end
         @(posedge clk); #1;
      end
      clear_inputs();
      #1;
      n_chk++; if (dmem_req_valid !== 1'b0 || mem_misalign !== 1'b0) begin n_err++;
         $display("FAIL misalign_after: got %b/%b want 0/0", dmem_req_valid, mem_misalign); end
      @(posedge clk); #1;
   endtask

   task automatic test_lwu_stall();
      do_mem(4'd7, 64'h2000, 64'h0, 64'hFFFF_FFFF_8000_0001, 5'd11, 3, 0, 0);
      n_chk++; if (o_unstable || o_req_n != 4 || o_req_addr !== 64'h2000) begin n_err++;
         $display("FAIL lwu_req: got unstable=%b reqcyc=%0d addr=%h want 0/4/2000",
         o_unstable, o_req_n, o_req_addr); end
      n_chk++; if (o_stalls != 6) begin n_err++;
         $display("FAIL lwu_stall: got %0d want 6", o_stalls); end
      n_chk++; if (o_res_data !== 64'h0000_0000_8000_0001) begin n_err++;
         $display("FAIL lwu_data: got %h want 0000000080000001", o_res_data); end
   endtask

   task automatic test_reset_wait();
      ex_valid_i = 1; ex_mem_op = 4'd4; ex_mem_addr = 64'h3000; ex_rd_addr = 9; ex_rd_ena = 1;
      ex_pc_i = 64'h44;
      @(posedge clk); #1;
      dmem_req_ready = 1;
      @(posedge clk); #1;
      dmem_req_ready = 0;
      n_chk++; if (mem_stall_req !== 1'b1 || dmem_req_valid !== 1'b0) begin n_err++;
         $display("FAIL rw_wait: got stall=%b req=%b want 1/0", mem_stall_req, dmem_req_valid);
      end
      rst = 0;
      #1;
      n_chk++; if (mem_stall_req !== 0 || dmem_req_addr !== 0 || mem_pc_o !== 0 ||
                   mem_rd_addr !== 0 || dmem_req_valid !== 0) begin n_err++;
         $display("FAIL rw_forced_zero: got stall=%b addr=%h pc=%h rd=%0d",
         mem_stall_req, dmem_req_addr, mem_pc_o, mem_rd_addr); end
      @(posedge clk); #1;
      rst = 1;
      clear_inputs();
      #1;
      n_chk++; if (mem_stall_req !== 1'b0 || dmem_req_valid !== 1'b0) begin n_err++;
         $display("FAIL rw_idle: got %b/%b want 0/0", mem_stall_req, dmem_req_valid); end
      dmem_resp_valid = 1; dmem_resp_rdata = 64'h5555;
      ex_valid_i = 1; ex_rd_data = 64'h77; ex_rd_addr = 6; ex_rd_ena = 1;
      @(posedge clk); #1;
      dmem_resp_valid = 0;
      n_chk++; if (mem_rd_data !== 64'h77 || mem_rd_addr !== 5'd6 || mem_stall_req !== 1'b0)
         begin n_err++; $display("FAIL rw_late_resp: got %h/%0d/%b want 77/6/0",
         mem_rd_data, mem_rd_addr, mem_stall_req); end
      clear_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      do_mem(4'd2, 64'h4002, 64'h0, 64'h0000_0000_8001_0000, 5'd13, 0, 1, 2);
      n_chk++; if (o_done_n != 3 || o_held_bad) begin n_err++;
         $display("FAIL hold_done: got cycles=%0d bad=%b want 3/0", o_done_n, o_held_bad); end
      n_chk++; if (o_res_data !== 64'hFFFF_FFFF_FFFF_8001 || o_stalls != 4) begin n_err++;
         $display("FAIL hold_data: got %h/%0d want ffffffffffff8001/4", o_res_data, o_stalls); end
      #1;
      n_chk++; if (mem_stall_req !== 1'b0 || dmem_req_valid !== 1'b0 || mem_rd_ena !== 1'b0)
         begin n_err++; $display("FAIL hold_idle: got %b/%b/%b want 0/0/0",
         mem_stall_req, dmem_req_valid, mem_rd_ena); end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [63:0] addr, wdata, rdata, exp;
      int          n, rdy_d, resp_d, hold_n, exp_st;
      logic        is_ld;
      for (int it = 0; it < 40; it++) begin
         // non-memory op pass-through
         ex_valid_i = 1'($urandom); ex_rd_ena = 1'($urandom); ex_rd_addr = 5'($urandom);
         ex_rd_data = {$urandom, $urandom}; ex_pc_i = {$urandom, $urandom};
         op = 4'($urandom_range(12, 16)); ex_mem_op = op;
         ex_mem_addr = {$urandom, $urandom};
         #1;
         n_chk++; if (mem_rd_data !== ex_rd_data || mem_rd_addr !== ex_rd_addr ||
                      mem_pc_o !== ex_pc_i || mem_rd_ena !== (ex_valid_i & ex_rd_ena) ||
                      mem_stall_req !== 1'b0) begin n_err++;
            $display("FAIL rnd_pass it%0d: got %h/%0d/%b/%b", it, mem_rd_data, mem_rd_addr,
            mem_rd_ena, mem_stall_req); end
         clear_inputs();
         @(posedge clk); #1;
         // memory op
         op = 4'($urandom_range(1, 11));
         n = nbytes(op);
         is_ld = (op <= 4'd7);
         addr = {$urandom, $urandom};
         addr = addr - (addr % 64'(n));
         wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
         rdy_d = $urandom_range(0, 3); resp_d = $urandom_range(0, 3);
         hold_n = $urandom_range(0, 2);
         do_mem(op, addr, wdata, rdata, 5'($urandom), rdy_d, resp_d, hold_n);
         exp_st = is_ld ? 3 + rdy_d + resp_d : 2 + rdy_d;
         n_chk++; if (o_timeout || o_stalls != exp_st || o_unstable || o_held_bad) begin
            n_err++; $display("FAIL rnd_timing it%0d op%0d: got to=%b st=%0d uns=%b hb=%b want st=%0d",
            it, op, o_timeout, o_stalls, o_unstable, o_held_bad, exp_st); end
         n_chk++; if (o_req_addr !== {addr[63:3], 3'b000} || o_req_wen !== !is_ld) begin
            n_err++; $display("FAIL rnd_req it%0d: got %h/%b want %h/%b", it, o_req_addr,
            o_req_wen, {addr[63:3], 3'b000}, !is_ld); end
         if (is_ld) begin
            exp = model_load(op, addr, rdata);
            n_chk++; if (o_res_data !== exp || o_res_ena !== 1'b1 || o_res_pc !== g_pc) begin
               n_err++; $display("FAIL rnd_load it%0d op%0d: got %h/%b want %h/1",
               it, op, o_res_data, o_res_ena, exp); end
         end else begin
            exp = wdata << (8 * int'(addr[2:0]));
            n_chk++; if (o_req_wdata !== exp || o_req_wstrb !== model_strb(op, addr) ||
                         o_res_ena !== 1'b0) begin n_err++;
               $display("FAIL rnd_store it%0d op%0d: got %h/%h/%b want %h/%h/0", it, op,
               o_req_wdata, o_req_wstrb, o_res_ena, exp, model_strb(op, addr)); end
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 0;
      @(posedge clk); #1;
      test_reset();
      test_alu();
      test_lb();
      test_sh();
      test_misalign();
      test_lwu_stall();
      test_reset_wait();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the 5-stage RV64 pipeline, sitting between the execute stage and the `mem_wb` pipeline register. It passes non-memory results straight through. Loads and stores run a small request/response FSM on the data-memory bus, during which the stage raises a stall request. Loads are aligned, lane-shifted and sign/zero-extended, and stores are given byte strobes. The outputs feed `mem_wb`'s `mem_rd_*` inputs and its PC input.

## Interface
Parameters:
- `XLEN`, 64: data/address width.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low: sampled on the `clk` rising edge, and a low level resets the block.
- `mem_hold_i`  in  1  downstream hold (stall_ctrl[4]); while 1, the DONE result is held.
- `ex_valid_i`  in  1  execute-stage outputs are valid.
- `ex_pc_i`  in  XLEN  PC of the instruction in this stage.
- `ex_rd_data`  in  XLEN  ALU result.
- `ex_rd_addr`  in  5  destination register.
- `ex_rd_ena`  in  1  write enable.
- `ex_mem_op`  in  4  0001 LB, 0010 LH, 0011 LW, 0100 LD, 0101 LBU, 0110 LHU, 0111 LWU, 1000 SB, 1001 SH, 1010 SW, 1011 SD; all other codes mean no memory operation.
- `ex_mem_addr`  in  XLEN  effective address.
- `ex_mem_wdata`  in  XLEN  store data in the low bytes.
- `dmem_req_valid`  out  1  bus request valid.
- `dmem_req_ready`  in  1  bus accepts the request.
- `dmem_req_addr`  out  XLEN  `{addr[XLEN-1:3],3'b000}`.
- `dmem_req_wen`  out  1  1 = store.
- `dmem_req_wdata`  out  XLEN  store data shifted into its byte lanes.
- `dmem_req_wstrb`  out  8  byte strobes.
- `dmem_resp_valid`  in  1  load data valid.
- `dmem_resp_rdata`  in  XLEN  aligned 8-byte word.
- `mem_rd_data`  out  XLEN  to `mem_wb`.
- `mem_rd_addr`  out  5  to `mem_wb`.
- `mem_rd_ena`  out  1  to `mem_wb`.
- `mem_pc_o`  out  XLEN  to `mem_wb` `wb_pc_i`.
- `mem_stall_req`  out  1  stall request to the pipeline control.
- `mem_misalign`  out  1  misaligned-access flag (1-cycle pulse per presentation).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE.
- IDLE, no memory op, or `ex_valid_i`=0:
  - `mem_rd_*` and `mem_pc_o` are combinational copies of the `ex_*` inputs.
  - `mem_stall_req`=0.
  - When `ex_valid_i`=0, `mem_rd_ena` is forced to 0.
- IDLE, valid memory op, misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0):
  - `mem_misalign`=1 and `mem_rd_ena`=0.
  - No bus request is made, no stall is raised, and the FSM stays in IDLE.
- IDLE, valid aligned memory op:
  - Latch op, addr, wdata, `rd_addr`, `rd_ena` and pc.
  - `mem_stall_req`=1; go to REQ.
- REQ:
  - `dmem_req_valid`=1; addr, wen, wdata and wstrb come from the latched values and stay stable until accepted.
  - On `dmem_req_ready`: a store goes to DONE, a load goes to WAIT.
- WAIT: on `dmem_resp_valid`, latch the extended load data and go to DONE.
- DONE:
  - `mem_stall_req`=0 and `mem_rd_*`/`mem_pc_o` come from the latched values.
  - Stay in DONE while `mem_hold_i`=1; otherwise go to IDLE.
  - The `ex_*` inputs still show the completed op and are ignored.
- Load extension:
  - Shift `rdata` right by 8*addr[2:0], then truncate to 8/16/32/64 bits.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
- Store lanes:
  - wdata = `ex_mem_wdata` << 8*addr[2:0].
  - wstrb = (0x01/0x03/0x0F/0xFF) << addr[2:0].
- For stores, `mem_rd_ena` is forced to 0 in DONE.
- `mem_stall_req` is 1 in REQ and WAIT, and also in IDLE in the cycle an aligned op is accepted.
- A `dmem_resp_valid` received outside WAIT is ignored.

## Timing
- Non-memory ops: 0-cycle combinational pass-through.
- Load, best case (ready in REQ, response one cycle later): IDLE→REQ→WAIT→DONE, result in the 4th cycle; stall asserted for 3 cycles.
- Store, best case: IDLE→REQ→DONE, stall asserted for 2 cycles.
- Each cycle of `ready`=0 or missing `resp_valid` adds one stall cycle.
- Reset values (`rst`=0 at an edge):
  - state = IDLE; all latches 0.
  - `dmem_req_valid`=0; `mem_stall_req`=0; `mem_misalign`=0.
  - `mem_rd_data`=0, `mem_rd_addr`=0, `mem_rd_ena`=0, `mem_pc_o`=0.
  - While `rst`=0, all outputs are forced to 0.
- Reset in REQ or WAIT: abandon the transaction; `dmem_req_valid`=0 from the next cycle; a late response is ignored.

## Test plan
- ALU op: `ex_rd_data`=0x1234, rd=5, `ex_mem_op`=0 → `mem_rd_data`=0x1234, addr 5, ena 1 in the same cycle; `mem_stall_req`=0.
- LB at addr 0x1003, rdata 0x00000000_80000000, ready immediate, response next cycle:
  - `dmem_req_addr`=0x1000.
  - DONE `mem_rd_data`=0xFFFFFFFF_FFFFFF80.
  - Stall high for exactly 3 cycles.
- SH at addr 0x1006, wdata 0xABCD:
  - `dmem_req_wstrb`=0xC0, `dmem_req_wdata`=0xABCD0000_00000000, `wen`=1.
  - DONE `mem_rd_ena`=0.
- LW at 0x1002 → `mem_misalign`=1, `mem_rd_ena`=0, `dmem_req_valid` never asserted, no stall.
- LWU with `ready` low for 3 cycles:
  - `req_valid`/`addr` stay stable; stall extends by 3 cycles.
  - rdata 0xFFFFFFFF_80000001 at addr 0x2000 → result 0x00000000_80000001.
- Other cases:
  - `rst`=0 during WAIT → IDLE next cycle and all outputs 0; a later `resp_valid` causes no write.
  - `mem_hold_i`=1 for 2 cycles in DONE → result held, then IDLE.
